// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the processor memory port: responder state
// encoding, data word width and the default wait-state count.
package cpu_mem_pkg;

    localparam int WORD_W          = 16;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_RESP  = 2'b10,
        ST_DRAIN = 2'b11
    } mem_state_e;

    // True when the word address has no bits set above the implemented range.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] a, input int aw);
        logic [WORD_W-1:0] hi;
        hi = a >> aw;
        return (hi == 16'd0);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Synchronous single-port word RAM. A read registers mem[addr] into the
// output on the enabled edge; the output holds between reads so it can be
// used directly as the responder's read-data register.
module word_ram
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_q;

    // Storage array: written on an enabled write edge, never reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read-data register: updated only by an enabled read, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 16'd0;
        end else if (i_en && !i_we) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: accepts one fetch/load/store at a time,
// inserts LATENCY wait cycles, pulses done, then waits for the requester
// to drop its request before accepting another.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ifetch,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    mem_state_e        r_state;
    mem_state_e        w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_is_write;
    logic              r_err;

    logic              w_read_cls;
    logic              w_any;
    logic              w_conflict;
    logic              w_oor;
    logic              w_accept;
    logic              w_reject;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_q;

    assign w_read_cls = req_ifetch | req_read;
    assign w_any      = w_read_cls | req_write;
    assign w_conflict = w_read_cls & req_write;
    assign w_oor      = ~addr_in_range(addr, ADDR_W);
    assign w_reject   = w_any & (w_conflict | w_oor);
    assign w_accept   = w_any & ~w_conflict & ~w_oor;

    // State register and the registered reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == ST_IDLE) && w_reject;
        end
    end

    // Request latches and wait counter; loaded only when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= 16'd0;
            r_is_write <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_accept) begin
            r_cnt      <= LAT_C;
            r_addr     <= addr[ADDR_W-1:0];
            r_wdata    <= wdata;
            r_is_write <= req_write;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt      <= r_cnt - 4'd1;
        end
    end

    // Next-state decode; the RAM is driven in the cycle before RESP so that
    // the write commits and read data lands on the edge entering RESP.
    always_comb begin
        w_next      = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_reject) begin
                    w_next = ST_DRAIN;
                end else if (w_accept) begin
                    if (LAT_C == 4'd0) begin
                        // Zero wait states: access straight from the request inputs.
                        w_next      = ST_RESP;
                        w_ram_en    = 1'b1;
                        w_ram_we    = req_write;
                        w_ram_addr  = addr[ADDR_W-1:0];
                        w_ram_wdata = wdata;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next   = ST_RESP;
                    w_ram_en = 1'b1;
                    w_ram_we = r_is_write;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_any) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    assign rdata = w_ram_q;
    assign done  = (r_state == ST_RESP);
    assign busy  = (r_state == ST_WAIT) || (r_state == ST_RESP);
    assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 (a_*) and one with
// LATENCY=0 (z_*). Expected read data is queued when a read is issued and
// popped when the responder signals done.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        a_f, a_r, a_w, z_f, z_r, z_w;
    logic [15:0] a_addr, a_wdata, a_rdata, z_addr, z_wdata, z_rdata;
    logic        a_done, a_busy, a_err, z_done, z_busy, z_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    mem_responder #(.ADDR_W(8), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req_ifetch(a_f), .req_read(a_r), .req_write(a_w),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .done(a_done), .busy(a_busy), .err(a_err)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(0)) dut_z (
        .clk(clk), .rst(rst), .req_ifetch(z_f), .req_read(z_r), .req_write(z_w),
        .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
        .done(z_done), .busy(z_busy), .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int which, input logic f, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (which == 0) begin
            a_f = f; a_r = r; a_w = w; a_addr = a; a_wdata = d;
        end else begin
            z_f = f; z_r = r; z_w = w; z_addr = a; z_wdata = d;
        end
    endtask

    task automatic sample(input int which, output logic dn, output logic bz,
                          output logic er, output logic [15:0] rd);
        if (which == 0) begin
            dn = a_done; bz = a_busy; er = a_err; rd = a_rdata;
        end else begin
            dn = z_done; bz = z_busy; er = z_err; rd = z_rdata;
        end
    endtask

    // Issue one request, wait (bounded) for done, then release and let the FSM drain.
    task automatic issue(input int which, input logic f, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         output int cyc, output int busy_cnt, output logic busy1,
                         output logic [15:0] rd, output logic timeout);
        logic dn, bz, er;
        logic [15:0] q;
        @(negedge clk);
        drive(which, f, r, w, a, d);
        cyc = 0; busy_cnt = 0; busy1 = 1'b0; rd = 16'd0; timeout = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            sample(which, dn, bz, er, q);
            if (i == 1) busy1 = bz;
            if (bz) busy_cnt++;
            if (dn) begin
                cyc = i; rd = q; timeout = 1'b0;
                break;
            end
        end
        drive(which, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_rdata, a_done, a_busy, a_err} !== 19'd0) begin
            n_fail++; $display("FAIL reset_a: got %h required 0", {a_rdata, a_done, a_busy, a_err});
        end
        n_checks++;
        if ({z_rdata, z_done, z_busy, z_err} !== 19'd0) begin
            n_fail++; $display("FAIL reset_z: got %h required 0", {z_rdata, z_done, z_busy, z_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store_fetch;
        int cyc, bc; logic b1, to; logic [15:0] rd, exp;
        issue(0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, cyc, bc, b1, rd, to);
        n_checks++;
        if (to !== 1'b0 || cyc != 3) begin
            n_fail++; $display("FAIL store_latency: got %0d (timeout %b) required 3", cyc, to);
        end
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++; $display("FAIL store_busy_k1: got %b required 1", b1);
        end
        exp_q.push_back(16'hBEEF);
        issue(0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, cyc, bc, b1, rd, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL fetch_rdata: got %h required %h", rd, exp);
        end
        n_checks++;
        if (to !== 1'b0 || cyc != 3 || bc != 3) begin
            n_fail++; $display("FAIL fetch_timing: got done@%0d busy %0d required done@3 busy 3", cyc, bc);
        end
    endtask

    task automatic test_lat0;
        int cyc, bc; logic b1, to; logic [15:0] rd, exp;
        issue(1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, cyc, bc, b1, rd, to);
        n_checks++;
        if (to !== 1'b0 || cyc != 1) begin
            n_fail++; $display("FAIL lat0_store: got %0d required 1", cyc);
        end
        exp_q.push_back(16'h1234);
        issue(1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, cyc, bc, b1, rd, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL lat0_rdata: got %h required %h", rd, exp);
        end
        n_checks++;
        if (to !== 1'b0 || cyc != 1 || bc != 1) begin
            n_fail++; $display("FAIL lat0_timing: got done@%0d busy %0d required done@1 busy 1", cyc, bc);
        end
    endtask

    task automatic test_held;
        int dones; logic dn, bz, er; logic [15:0] q, got, exp;
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        dones = 0; got = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample(0, dn, bz, er, q);
            if (dn) begin dones++; got = q; end
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL held_single_done: got %0d pulses required 1", dones);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL held_rdata: got %h required %h", got, exp);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample(0, dn, bz, er, q);
            if (dn) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL held_rearm: got %0d pulses required 1", dones);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reject;
        int cyc, bc; logic b1, to; logic [15:0] rd, exp;
        issue(0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1111, cyc, bc, b1, rd, to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++; $display("FAIL preload0_timeout: got timeout %b required 0", to);
        end
        // Read and write together at an address holding 0xBEEF.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
        @(negedge clk);
        n_checks++;
        if ({a_err, a_busy, a_done} !== 3'b100) begin
            n_fail++; $display("FAIL conflict_err: got err/busy/done %b required 100", {a_err, a_busy, a_done});
        end
        @(negedge clk);
        n_checks++;
        if ({a_err, a_busy, a_done} !== 3'b000 || a_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL conflict_after: got %b rdata %h required 000 rdata beef",
                               {a_err, a_busy, a_done}, a_rdata);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        exp_q.push_back(16'hBEEF);
        issue(0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, cyc, bc, b1, rd, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL conflict_mem: got %h required %h", rd, exp);
        end
        // Out-of-range store whose low bits alias word 0.
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h7777);
        @(negedge clk);
        n_checks++;
        if ({a_err, a_busy, a_done} !== 3'b100) begin
            n_fail++; $display("FAIL range_err: got err/busy/done %b required 100", {a_err, a_busy, a_done});
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        exp_q.push_back(16'h1111);
        issue(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, cyc, bc, b1, rd, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL range_mem: got %h required %h", rd, exp);
        end
    endtask

    task automatic test_reset_mid_write;
        int cyc, bc; logic b1, to; logic [15:0] rd, exp;
        issue(0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h5555, cyc, bc, b1, rd, to);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'hAAAA);
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++; $display("FAIL midwr_busy: got %b required 1", a_busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_rdata, a_done, a_busy, a_err} !== 19'd0 || {z_rdata, z_done, z_busy, z_err} !== 19'd0) begin
            n_fail++; $display("FAIL midwr_reset_outs: got a=%h z=%h required 0",
                               {a_rdata, a_done, a_busy, a_err}, {z_rdata, z_done, z_busy, z_err});
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(16'h5555);
        issue(0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, cyc, bc, b1, rd, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (to !== 1'b0 || rd !== exp) begin
            n_fail++; $display("FAIL midwr_discard: got %h (timeout %b) required %h", rd, to, exp);
        end
    endtask

    initial begin
        test_reset();
        test_store_fetch();
        test_lat0();
        test_held();
        test_reject();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Wait-stated memory responder on the processor's memory port. Serves the controller's instruction fetch, load and store requests against a single 16-bit word-addressed memory. Inserts a programmable number of wait cycles and signals completion with a one-cycle `done` pulse, so a stalling controller can hold in its fetch and memory states until the access finishes.

## Interface
- `ADDR_W`, default 8: implemented word-address bits. Depth is 2^ADDR_W words.
- `LATENCY`, default 2: wait cycles between request acceptance and response. Range 0..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_ifetch` in 1: instruction-fetch read request, level.
- `req_read` in 1: data-load request, level.
- `req_write` in 1: data-store request, level.
- `addr` in 16: word address.
- `wdata` in 16: store data.
- `rdata` out 16: read data, registered.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: access in progress; new requests are not accepted.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- **States:** IDLE, WAIT, RESP, DRAIN. Reset state is IDLE.
- **Reset values:** `rdata`=0, `done`=0, `busy`=0, `err`=0, wait counter=0. Memory contents are not reset.
- **IDLE:** sample the request. Read-class = `req_ifetch` | `req_read`.
  - No request: stay in IDLE.
  - Read-class and `req_write` both high: pulse `err` next cycle, go to DRAIN, no access.
  - `addr[15:ADDR_W]` ≠ 0: pulse `err`, go to DRAIN, no access.
  - Otherwise: latch `addr`, `wdata` and the operation. Load the counter with LATENCY. Go to WAIT, or to RESP if LATENCY=0.
- **WAIT:** decrement the counter each cycle. Go to RESP on the edge where the counter reaches 1. Request inputs and `addr`/`wdata` are ignored.
- **Edge entering RESP:**
  - A write commits the latched `wdata` to `mem[addr]`.
  - A read loads `rdata` from `mem[addr]`.
  - `req_ifetch` and `req_read` behave identically.
- **RESP:** `done`=1 for exactly this cycle. Next state is DRAIN.
- **DRAIN:** wait until all three requests are low, then return to IDLE. A request still held after `done` is therefore never serviced twice.
- `busy`=1 in WAIT and RESP; 0 in IDLE and DRAIN.
- `rdata` holds its value until the next completed read. Writes and rejected requests leave it unchanged.
- Read-after-write to the same address returns the new data.
- **Reset mid-operation:** immediate return to IDLE. A write not yet committed (still in WAIT) is discarded. A write already committed stays committed.

## Timing
- Request high at IDLE edge k → `busy` high from cycle k+1 → `done` high in cycle k+LATENCY+1, with `rdata` valid in that same cycle. Accept-to-done latency is LATENCY+1 cycles.
- With LATENCY=0, `done` is high in cycle k+1.
- `err` is high in cycle k+1 for a rejected request; `busy` stays 0.
- Minimum request spacing: the requester must drop all requests for at least one cycle after `done`. The earliest next acceptance is at the first IDLE edge after that.
- `done`, `busy` and `err` are decoded from the state register only; there are no combinational input-to-output paths.

## Structure
- **Shared package `cpu_mem_pkg`:** state encoding (2-bit: IDLE=00, WAIT=01, RESP=10, DRAIN=11), 16-bit word width constant, default LATENCY. `controllerFSM` and the datapath import it later.
- **Sub-module `word_ram`:** synchronous single-port RAM, 2^ADDR_W×16, with write enable. Read data is available the cycle after the address is presented; the responder presents the address in the cycle before RESP.
- **Top level:** FSM, wait counter, and request/address/data latches.

## Test plan
- **Store then fetch, LATENCY=2:** `req_write` with `addr`=0x0005, `wdata`=0xBEEF. `done` is seen 3 cycles after acceptance. Drop the request, then `req_ifetch` at 0x0005 → `rdata`=0xBEEF in the `done` cycle.
- **LATENCY=0:** `req_read` at 0x0010 after a store of 0x1234 → `done` 1 cycle after acceptance, `rdata`=0x1234, `busy` high for exactly 1 cycle.
- **Held request:** keep `req_read` high for 10 cycles → exactly one `done` pulse. A second `done` follows only after a low cycle and re-assertion.
- **Rejects:** `req_read` and `req_write` together → `err` pulse, `busy`=0, memory and `rdata` unchanged. `addr`=0x0100 with ADDR_W=8 → `err` pulse, no access.
- **Reset mid-write:** `req_write` 0x0003←0xAAAA, assert `rst` during WAIT, then read 0x0003 → prior value (0x5555 preloaded). All outputs are 0 during reset.
